// File: rtl/regfile_rename_ckpt.sv
// regfile_rename_ckpt
// Architectural register file with per-register rename state (dirty bit plus
// ROB tag) and a circular FIFO of rename-table checkpoints. A mispredict
// restores the rename table saved at that branch. A flush clears all rename
// state.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   i_rdy             global enable; state holds when low, reads stay live
//   i_rs{1,2}_idx     read indices -> o_rs{1,2}_{dirty,tag,val}. A commit in
//                     the same cycle that matches the tag is bypassed.
//   i_ren_*           rename a destination to a ROB tag
//   i_cm_*            ROB commit: write the value, clear the dirty bit on a
//                     tag match
//   i_ck_take         push a checkpoint at the tail (o_ck_id)
//   o_ck_full         all checkpoint slots in use
//   i_ck_release      pop the oldest checkpoint
//   i_rb_en/i_rb_id   restore the rename table from a checkpoint slot
//   i_flush           clear all rename state and checkpoints
module regfile_rename_ckpt #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned ROB_W  = 4,
    parameter int unsigned NCKPT  = 4,
    parameter int unsigned CK_W   = 2,
    localparam int unsigned RIDX_W = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rdy,
    input  logic [RIDX_W-1:0] i_rs1_idx,
    output logic              o_rs1_dirty,
    output logic [ROB_W-1:0]  o_rs1_tag,
    output logic [XLEN-1:0]   o_rs1_val,
    input  logic [RIDX_W-1:0] i_rs2_idx,
    output logic              o_rs2_dirty,
    output logic [ROB_W-1:0]  o_rs2_tag,
    output logic [XLEN-1:0]   o_rs2_val,
    input  logic              i_ren_en,
    input  logic [RIDX_W-1:0] i_ren_rd,
    input  logic [ROB_W-1:0]  i_ren_tag,
    input  logic              i_cm_en,
    input  logic [RIDX_W-1:0] i_cm_rd,
    input  logic [XLEN-1:0]   i_cm_val,
    input  logic [ROB_W-1:0]  i_cm_tag,
    input  logic              i_ck_take,
    output logic [CK_W-1:0]   o_ck_id,
    output logic              o_ck_full,
    input  logic              i_ck_release,
    input  logic              i_rb_en,
    input  logic [CK_W-1:0]   i_rb_id,
    input  logic              i_flush
);

    // Architectural state
    logic [XLEN-1:0]  r_val [NREG];
    logic [NREG-1:0]  r_dirty;
    logic [ROB_W-1:0] r_tag [NREG];

    // Checkpoint FIFO. Slot validity is implied by head/count.
    logic [NREG-1:0]  r_ck_dirty [NCKPT];
    logic [ROB_W-1:0] r_ck_tag   [NCKPT][NREG];
    logic [CK_W-1:0]  r_head;
    logic [CK_W-1:0]  r_tail;
    logic [CK_W:0]    r_count;

    // Next-state
    logic [NREG-1:0]  w_dirty_n;
    logic [ROB_W-1:0] w_tag_n [NREG];
    logic [NREG-1:0]  w_ck_dirty_n [NCKPT];
    logic [ROB_W-1:0] w_ck_tag_n   [NCKPT][NREG];
    logic [CK_W-1:0]  w_head_n;
    logic [CK_W-1:0]  w_tail_n;
    logic [CK_W:0]    w_count_n;

    logic             w_cm_ok;
    logic             w_full;
    logic [CK_W-1:0]  w_rb_off;

    assign w_cm_ok  = i_cm_en && (i_cm_rd != '0);
    assign w_full   = (r_count == (CK_W+1)'(NCKPT));
    assign w_rb_off = i_rb_id - r_head;

    assign o_ck_id   = r_tail;
    assign o_ck_full = w_full;

    // Read port: {dirty, tag, val}
    function automatic logic [XLEN+ROB_W:0] rd_port(input logic [RIDX_W-1:0] idx);
        logic [XLEN+ROB_W:0] res;
        if (idx == '0) begin
            res = '0;
        end else if (i_cm_en && (i_cm_rd == idx) && r_dirty[idx] && (r_tag[idx] == i_cm_tag)) begin
            res = {1'b0, {ROB_W{1'b0}}, i_cm_val};
        end else begin
            res = {r_dirty[idx], r_tag[idx], r_val[idx]};
        end
        return res;
    endfunction

    assign {o_rs1_dirty, o_rs1_tag, o_rs1_val} = rd_port(i_rs1_idx);
    assign {o_rs2_dirty, o_rs2_tag, o_rs2_val} = rd_port(i_rs2_idx);

    always_comb begin
        w_dirty_n    = r_dirty;
        w_tag_n      = r_tag;
        w_ck_dirty_n = r_ck_dirty;
        w_ck_tag_n   = r_ck_tag;
        w_head_n     = r_head;
        w_tail_n     = r_tail;
        w_count_n    = r_count;

        if (i_flush) begin
            w_dirty_n = '0;
            for (int i = 0; i < NREG; i++) begin
                w_tag_n[i] = '0;
            end
            w_head_n  = '0;
            w_tail_n  = '0;
            w_count_n = '0;
        end else begin
            // Commit clear on the live table and on every checkpoint slot.
            // Invalid slots are overwritten before reuse, so clearing them is harmless.
            if (w_cm_ok && r_dirty[i_cm_rd] && (r_tag[i_cm_rd] == i_cm_tag)) begin
                w_dirty_n[i_cm_rd] = 1'b0;
                w_tag_n[i_cm_rd]   = '0;
            end
            for (int s = 0; s < NCKPT; s++) begin
                if (w_cm_ok && r_ck_dirty[s][i_cm_rd] && (r_ck_tag[s][i_cm_rd] == i_cm_tag)) begin
                    w_ck_dirty_n[s][i_cm_rd] = 1'b0;
                    w_ck_tag_n[s][i_cm_rd]   = '0;
                end
            end

            if (i_rb_en) begin
                // Restore from the commit-cleared slot; the restored slot stays valid
                w_dirty_n = w_ck_dirty_n[i_rb_id];
                w_tag_n   = w_ck_tag_n[i_rb_id];
                w_tail_n  = i_rb_id + CK_W'(1);
                w_count_n = {1'b0, w_rb_off} + (CK_W+1)'(1);
                // Release after rollback; count is never zero here
                if (i_ck_release) begin
                    w_head_n  = r_head + CK_W'(1);
                    w_count_n = {1'b0, w_rb_off};
                end
            end else begin
                if (i_ren_en && (i_ren_rd != '0)) begin
                    w_dirty_n[i_ren_rd] = 1'b1;
                    w_tag_n[i_ren_rd]   = i_ren_tag;
                end
                // Snapshot is the post-commit, post-rename table
                if (i_ck_take && !w_full) begin
                    w_ck_dirty_n[r_tail] = w_dirty_n;
                    w_ck_tag_n[r_tail]   = w_tag_n;
                    w_tail_n             = r_tail + CK_W'(1);
                    w_count_n            = w_count_n + (CK_W+1)'(1);
                end
                if (i_ck_release && (r_count != '0)) begin
                    w_head_n  = r_head + CK_W'(1);
                    w_count_n = w_count_n - (CK_W+1)'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_val[i] <= '0;
                r_tag[i] <= '0;
            end
            r_dirty <= '0;
            for (int s = 0; s < NCKPT; s++) begin
                r_ck_dirty[s] <= '0;
                for (int i = 0; i < NREG; i++) begin
                    r_ck_tag[s][i] <= '0;
                end
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_rdy) begin
            if (w_cm_ok) begin
                r_val[i_cm_rd] <= i_cm_val;
            end
            r_dirty    <= w_dirty_n;
            r_tag      <= w_tag_n;
            r_ck_dirty <= w_ck_dirty_n;
            r_ck_tag   <= w_ck_tag_n;
            r_head     <= w_head_n;
            r_tail     <= w_tail_n;
            r_count    <= w_count_n;
        end
    end

    // Rollback target must be a live checkpoint
    a_rb_in_range: assert property (@(posedge clk) disable iff (rst)
        (i_rdy && i_rb_en && !i_flush) |-> ({1'b0, w_rb_off} < r_count));

endmodule

// File: tb/tb_regfile_rename_ckpt.sv
module tb_regfile_rename_ckpt;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic [4:0]  rs1_idx, rs2_idx;
    logic        rs1_dirty, rs2_dirty;
    logic [3:0]  rs1_tag, rs2_tag;
    logic [31:0] rs1_val, rs2_val;
    logic        ren_en;
    logic [4:0]  ren_rd;
    logic [3:0]  ren_tag;
    logic        cm_en;
    logic [4:0]  cm_rd;
    logic [31:0] cm_val;
    logic [3:0]  cm_tag;
    logic        ck_take;
    logic [1:0]  ck_id;
    logic        ck_full;
    logic        ck_release;
    logic        rb_en;
    logic [1:0]  rb_id;
    logic        flush;

    regfile_rename_ckpt dut (
        .clk          (clk),
        .rst          (rst),
        .i_rdy        (rdy),
        .i_rs1_idx    (rs1_idx),
        .o_rs1_dirty  (rs1_dirty),
        .o_rs1_tag    (rs1_tag),
        .o_rs1_val    (rs1_val),
        .i_rs2_idx    (rs2_idx),
        .o_rs2_dirty  (rs2_dirty),
        .o_rs2_tag    (rs2_tag),
        .o_rs2_val    (rs2_val),
        .i_ren_en     (ren_en),
        .i_ren_rd     (ren_rd),
        .i_ren_tag    (ren_tag),
        .i_cm_en      (cm_en),
        .i_cm_rd      (cm_rd),
        .i_cm_val     (cm_val),
        .i_cm_tag     (cm_tag),
        .i_ck_take    (ck_take),
        .o_ck_id      (ck_id),
        .o_ck_full    (ck_full),
        .i_ck_release (ck_release),
        .i_rb_en      (rb_en),
        .i_rb_id      (rb_id),
        .i_flush      (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        nrdy;
        logic        re;
        logic [4:0]  rrd;
        logic [3:0]  rtag;
        logic        ce;
        logic [4:0]  crd;
        logic [31:0] cval;
        logic [3:0]  ctag;
        logic        take;
        logic        rel;
        logic        rb;
        logic [1:0]  rbid;
        logic        fl;
        logic [4:0]  i1;
        logic [4:0]  i2;
        // expected outputs, each group checked only when its c* flag is set
        logic        c1;
        logic        d1;
        logic [3:0]  t1;
        logic [31:0] v1;
        logic        c2;
        logic        d2;
        logic [3:0]  t2;
        logic [31:0] v2;
        logic        cc;
        logic [1:0]  cid;
        logic        cfull;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk_rd(input string nm, input int k, input logic d, input logic [3:0] t,
                          input logic [31:0] v, input logic ed, input logic [3:0] et,
                          input logic [31:0] ev);
        checks++;
        if ({d, t, v} !== {ed, et, ev}) begin
            errors++;
            $display("FAIL %s step %0d: got dirty=%0b tag=%0d val=%h, want dirty=%0b tag=%0d val=%h",
                     nm, k, d, t, v, ed, et, ev);
        end
    endtask

    task automatic chk_ck(input string nm, input int k, input logic [1:0] id, input logic full,
                          input logic [1:0] eid, input logic efull);
        checks++;
        if ({id, full} !== {eid, efull}) begin
            errors++;
            $display("FAIL %s step %0d: got ck_id=%0d ck_full=%0b, want ck_id=%0d ck_full=%0b",
                     nm, k, id, full, eid, efull);
        end
    endtask

    task automatic drive(input vec_t v);
        rdy        = !v.nrdy;
        ren_en     = v.re;
        ren_rd     = v.rrd;
        ren_tag    = v.rtag;
        cm_en      = v.ce;
        cm_rd      = v.crd;
        cm_val     = v.cval;
        cm_tag     = v.ctag;
        ck_take    = v.take;
        ck_release = v.rel;
        rb_en      = v.rb;
        rb_id      = v.rbid;
        flush      = v.fl;
        rs1_idx    = v.i1;
        rs2_idx    = v.i2;
    endtask

    initial begin
        vec_t idle;
        vec_t e;
        idle = '{default: 0};

        // Commit bypass (test 1)
        vecs.push_back('{re:1, rrd:5, rtag:3, i1:5, c1:1, cc:1, default:0});
        vecs.push_back('{ce:1, crd:5, cval:'hDEAD, ctag:3, i1:5, c1:1, v1:'hDEAD, default:0});
        vecs.push_back('{i1:5, c1:1, v1:'hDEAD, default:0});
        // Stale commit does not clear a newer rename (test 2)
        vecs.push_back('{re:1, rrd:7, rtag:2, i1:7, c1:1, default:0});
        vecs.push_back('{re:1, rrd:7, rtag:6, i1:7, c1:1, d1:1, t1:2, default:0});
        vecs.push_back('{ce:1, crd:7, cval:9, ctag:2, i1:7, c1:1, d1:1, t1:6, default:0});
        vecs.push_back('{i1:7, c1:1, d1:1, t1:6, v1:9, default:0});
        // Commit clear reaches checkpoint slot (test 3)
        vecs.push_back('{re:1, rrd:1, rtag:1, i1:1, c1:1, default:0});
        vecs.push_back('{take:1, i1:1, c1:1, d1:1, t1:1, cc:1, default:0});
        vecs.push_back('{re:1, rrd:1, rtag:4, i1:1, c1:1, d1:1, t1:1, cc:1, cid:1, default:0});
        vecs.push_back('{ce:1, crd:1, cval:'h11, ctag:1, i1:1, c1:1, d1:1, t1:4, default:0});
        vecs.push_back('{rb:1, rbid:0, i1:1, c1:1, d1:1, t1:4, v1:'h11, default:0});
        vecs.push_back('{i1:1, c1:1, v1:'h11, i2:7, c2:1, d2:1, t2:6, v2:9, cc:1, cid:1, default:0});
        // Fill to full, overflow take ignored, release wraps (test 4)
        vecs.push_back('{take:1, cc:1, cid:1, default:0});
        vecs.push_back('{take:1, cc:1, cid:2, default:0});
        vecs.push_back('{take:1, cc:1, cid:3, default:0});
        vecs.push_back('{take:1, cc:1, cid:0, cfull:1, default:0});
        vecs.push_back('{cc:1, cfull:1, default:0});
        vecs.push_back('{rel:1, cc:1, cfull:1, default:0});
        vecs.push_back('{cc:1, default:0});
        // Rollback to middle slot (test 5)
        vecs.push_back('{fl:1, cc:1, default:0});
        vecs.push_back('{re:1, rrd:2, rtag:5, default:0});
        vecs.push_back('{take:1, cc:1, default:0});
        vecs.push_back('{re:1, rrd:2, rtag:6, take:1, cc:1, cid:1, default:0});
        vecs.push_back('{re:1, rrd:2, rtag:7, take:1, i1:2, c1:1, d1:1, t1:6, cc:1, cid:2, default:0});
        vecs.push_back('{rb:1, rbid:1, re:1, rrd:3, rtag:1, take:1, i1:2, c1:1, d1:1, t1:7,
                         cc:1, cid:3, default:0});
        vecs.push_back('{i1:2, c1:1, d1:1, t1:6, i2:3, c2:1, cc:1, cid:2, default:0});
        vecs.push_back('{take:1, cc:1, cid:2, default:0});
        vecs.push_back('{take:1, cc:1, cid:3, default:0});
        vecs.push_back('{cc:1, cid:0, cfull:1, default:0});
        // Flush with commit and rename (test 6), then register 0
        vecs.push_back('{fl:1, ce:1, crd:3, cval:5, re:1, rrd:4, rtag:2, take:1, cc:1, cfull:1,
                         default:0});
        vecs.push_back('{i1:3, c1:1, v1:5, i2:4, c2:1, cc:1, default:0});
        vecs.push_back('{re:1, rrd:0, rtag:5, ce:1, crd:0, cval:'hBEEF, ctag:5, i1:0, c1:1,
                         default:0});
        vecs.push_back('{c1:1, c2:1, default:0});
        // rdy low holds all state
        vecs.push_back('{nrdy:1, re:1, rrd:9, rtag:3, take:1, default:0});
        vecs.push_back('{i1:9, c1:1, cc:1, default:0});
        // Rollback with same-cycle release pops the restored slot
        vecs.push_back('{re:1, rrd:8, rtag:1, take:1, cc:1, default:0});
        vecs.push_back('{re:1, rrd:8, rtag:2, take:1, cc:1, cid:1, default:0});
        vecs.push_back('{rb:1, rbid:0, rel:1, i1:8, c1:1, d1:1, t1:2, cc:1, cid:2, default:0});
        vecs.push_back('{i1:8, c1:1, d1:1, t1:1, cc:1, cid:1, default:0});
        // Release on empty is ignored: exactly four takes to full
        vecs.push_back('{rel:1, default:0});
        vecs.push_back('{take:1, cc:1, cid:1, default:0});
        vecs.push_back('{take:1, cc:1, cid:2, default:0});
        vecs.push_back('{take:1, cc:1, cid:3, default:0});
        vecs.push_back('{take:1, cc:1, cid:0, default:0});
        vecs.push_back('{cc:1, cid:1, cfull:1, default:0});

        // Reset
        drive(idle);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rs1_idx = 5'd5;
        #2;
        chk_rd("reset_rs1", -1, rs1_dirty, rs1_tag, rs1_val, 1'b0, 4'd0, 32'd0);
        chk_rd("reset_rs2", -1, rs2_dirty, rs2_tag, rs2_val, 1'b0, 4'd0, 32'd0);
        chk_ck("reset_ck", -1, ck_id, ck_full, 2'd0, 1'b0);

        // Table: drive at negedge, expected goes to the scoreboard, popped at sample
        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            drive(vecs[k]);
            sb.push_back(vecs[k]);
            #2;
            e = sb.pop_front();
            if (e.c1) chk_rd("rs1", k, rs1_dirty, rs1_tag, rs1_val, e.d1, e.t1, e.v1);
            if (e.c2) chk_rd("rs2", k, rs2_dirty, rs2_tag, rs2_val, e.d2, e.t2, e.v2);
            if (e.cc) chk_ck("ckpt", k, ck_id, ck_full, e.cid, e.cfull);
        end

        // Mid-operation reset discards pending tags and checkpoints
        @(negedge clk);
        drive(idle);
        ren_en = 1'b1; ren_rd = 5'd6; ren_tag = 4'd9;
        @(negedge clk);
        drive(idle);
        rs1_idx = 5'd6;
        #2;
        chk_rd("pre_rst_x6", 100, rs1_dirty, rs1_tag, rs1_val, 1'b1, 4'd9, 32'd0);
        chk_ck("pre_rst_ck", 100, ck_id, ck_full, 2'd1, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        ren_en = 1'b1; ren_rd = 5'd6; ren_tag = 4'd2;
        @(negedge clk);
        rst = 1'b0;
        drive(idle);
        rs1_idx = 5'd6;
        rs2_idx = 5'd3;
        #2;
        chk_rd("post_rst_x6", 101, rs1_dirty, rs1_tag, rs1_val, 1'b0, 4'd0, 32'd0);
        chk_rd("post_rst_x3", 101, rs2_dirty, rs2_tag, rs2_val, 1'b0, 4'd0, 32'd0);
        chk_ck("post_rst_ck", 101, ck_id, ck_full, 2'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
